// File: rtl/dbus_responder_if.sv
// Request/response signal bundle between a dbus initiator and the memory-side responder.
// The master drives requests; the slave returns acceptance, completion and read data.
interface dbus_responder_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface

// File: rtl/dbus_responder.sv
// Memory-side dbus responder: serves one load/store at a time from a 64-bit-word array
// with a fixed, parameterised wait between acceptance and the one-cycle completion pulse.
module dbus_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  dbus_responder_if.slave   bus
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = BASE + (64'(DEPTH) << 3);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        r_data_ok;
  logic        r_err;
  logic [63:0] r_rdata;
  logic [63:0] r_mem [DEPTH];

  logic          w_take;
  logic [63:0]   w_addr;
  logic [2:0]    w_size;
  logic [7:0]    w_strobe;
  logic [63:0]   w_data;
  logic          w_misalign;
  logic          w_legal;
  logic          w_store;
  logic          w_commit;
  logic [63:0]   w_off;
  logic [AW-1:0] w_idx;

  assign w_take = bus.req_valid && (r_state == IDLE);

  // With zero latency the access happens on the acceptance edge, so the live inputs are used.
  assign w_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_size   = (r_state == IDLE) ? bus.req_size   : r_size;
  assign w_strobe = (r_state == IDLE) ? bus.req_strobe : r_strobe;
  assign w_data   = (r_state == IDLE) ? bus.req_data   : r_data;

  always_comb begin
    w_misalign = 1'b1;
    case (w_size)
      3'd0:    w_misalign = 1'b0;
      3'd1:    w_misalign = w_addr[0];
      3'd2:    w_misalign = |w_addr[1:0];
      3'd3:    w_misalign = |w_addr[2:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_legal  = (w_addr >= BASE) && (w_addr < LIMIT) && !w_misalign;
  assign w_store  = |w_strobe;
  assign w_off    = w_addr - BASE;
  assign w_idx    = AW'(w_off >> 3);
  assign w_commit = (w_take && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == 4'd1));

  // Single write port; gated by reset so a held reset never commits a store.
  always_ff @(posedge clk) begin
    if (reset && w_commit && w_legal && w_store) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strobe[i]) r_mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_size    <= '0;
      r_strobe  <= '0;
      r_data    <= '0;
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_ok <= 1'b0;
          r_err     <= 1'b0;
          r_rdata   <= '0;
          if (w_take) begin
            r_addr   <= bus.req_addr;
            r_size   <= bus.req_size;
            r_strobe <= bus.req_strobe;
            r_data   <= bus.req_data;
            r_cnt    <= LAT;
            if (LATENCY == 0) begin
              r_state   <= RESP;
              r_data_ok <= 1'b1;
              r_err     <= !w_legal;
              r_rdata   <= (w_legal && !w_store) ? r_mem[w_idx] : '0;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= RESP;
            r_data_ok <= 1'b1;
            r_err     <= !w_legal;
            r_rdata   <= (w_legal && !w_store) ? r_mem[w_idx] : '0;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_data_ok <= 1'b0;
          r_err     <= 1'b0;
          r_rdata   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.resp_addr_ok = w_take;
  assign bus.resp_data_ok = r_data_ok;
  assign bus.resp_err     = r_err;
  assign bus.resp_data    = r_rdata;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_dbus_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_responder_if bus2();
  dbus_responder_if bus0();

  dbus_responder #(.DEPTH(1024), .LATENCY(2), .BASE(64'h8000_0000)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));
  dbus_responder #(.DEPTH(1024), .LATENCY(0), .BASE(64'h8000_0000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_req(input bit l0, input logic v, input logic [63:0] a,
                         input logic [2:0] s, input logic [7:0] st, input logic [63:0] d);
    if (l0) begin
      bus0.req_valid = v; bus0.req_addr = a; bus0.req_size = s;
      bus0.req_strobe = st; bus0.req_data = d;
    end else begin
      bus2.req_valid = v; bus2.req_addr = a; bus2.req_size = s;
      bus2.req_strobe = st; bus2.req_data = d;
    end
  endtask

  function automatic logic get_dok(input bit l0);
    return l0 ? bus0.resp_data_ok : bus2.resp_data_ok;
  endfunction

  // One full transaction: returns addr_ok in the drive cycle and the cycle offset of data_ok.
  task automatic xfer(input bit l0, input logic [63:0] a, input logic [2:0] s,
                      input logic [7:0] st, input logic [63:0] d,
                      output logic ao, output int lat, output logic [63:0] rd, output logic er);
    @(negedge clk);
    set_req(l0, 1'b1, a, s, st, d);
    #1;
    ao  = l0 ? bus0.resp_addr_ok : bus2.resp_addr_ok;
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (get_dok(l0)) begin
        lat = c;
        rd  = l0 ? bus0.resp_data : bus2.resp_data;
        er  = l0 ? bus0.resp_err  : bus2.resp_err;
        break;
      end
    end
    set_req(l0, 1'b0, '0, 3'd0, 8'h00, '0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_req(1'b0, 1'b0, '0, 3'd0, 8'h00, '0);
    set_req(1'b1, 1'b0, '0, 3'd0, 8'h00, '0);
    @(negedge clk); #1;
    n_cmp++;
    if (bus2.resp_data_ok !== 1'b0 || bus2.resp_err !== 1'b0 || bus2.resp_data !== 64'h0 ||
        bus2.resp_addr_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got dok=%b err=%b data=%h aok=%b want all 0",
               bus2.resp_data_ok, bus2.resp_err, bus2.resp_data, bus2.resp_addr_ok);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_load;
    logic ao, er; int lat; logic [63:0] rd;
    xfer(1'b0, 64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, ao, lat, rd, er);
    n_cmp++;
    if (ao !== 1'b1 || lat != 3 || er !== 1'b0) begin
      n_bad++; $display("FAIL store_timing got aok=%b lat=%0d err=%b want 1 3 0", ao, lat, er);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus2.resp_data_ok !== 1'b0) begin
      n_bad++; $display("FAIL store_pulse_width got dok=%b want 0 in cycle 4", bus2.resp_data_ok);
    end
    xfer(1'b0, 64'h8000_0008, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (lat != 3 || rd !== 64'h1122_3344_5566_7788 || er !== 1'b0) begin
      n_bad++; $display("FAIL load_back got lat=%0d data=%h err=%b want 3 1122334455667788 0", lat, rd, er);
    end
  endtask

  task automatic test_byte_merge;
    logic ao, er; int lat; logic [63:0] rd;
    xfer(1'b0, 64'h8000_0010, 3'd3, 8'hFF, 64'h0, ao, lat, rd, er);
    xfer(1'b0, 64'h8000_0010, 3'd3, 8'h0C, 64'h1111_AABB_CCDD_2222, ao, lat, rd, er);
    xfer(1'b0, 64'h8000_0010, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (rd !== 64'h0000_0000_CCDD_0000 || er !== 1'b0) begin
      n_bad++; $display("FAIL merge_0C got %h err=%b want 00000000ccdd0000 0", rd, er);
    end
    xfer(1'b0, 64'h8000_0010, 3'd3, 8'h30, 64'h1111_AABB_CCDD_2222, ao, lat, rd, er);
    xfer(1'b0, 64'h8000_0010, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (rd !== 64'h0000_AABB_CCDD_0000) begin
      n_bad++; $display("FAIL merge_30 got %h want 0000aabbccdd0000", rd);
    end
  endtask

  task automatic test_latency0;
    logic ao, er; int lat; logic [63:0] rd;
    xfer(1'b1, 64'h8000_0008, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, ao, lat, rd, er);
    n_cmp++;
    if (ao !== 1'b1 || lat != 1 || er !== 1'b0) begin
      n_bad++; $display("FAIL lat0_store got aok=%b lat=%0d err=%b want 1 1 0", ao, lat, er);
    end
    @(negedge clk);
    set_req(1'b1, 1'b1, 64'h8000_0008, 3'd3, 8'h00, '0);
    #1;
    n_cmp++;
    if (bus0.resp_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL lat0_accept got aok=%b want 1", bus0.resp_addr_ok);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus0.resp_data_ok !== 1'b1 || bus0.resp_addr_ok !== 1'b0 ||
        bus0.resp_data !== 64'h0123_4567_89AB_CDEF) begin
      n_bad++; $display("FAIL lat0_resp got dok=%b aok=%b data=%h want 1 0 0123456789abcdef",
                        bus0.resp_data_ok, bus0.resp_addr_ok, bus0.resp_data);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus0.resp_data_ok !== 1'b0 || bus0.resp_addr_ok !== 1'b1 || bus0.resp_data !== 64'h0) begin
      n_bad++; $display("FAIL lat0_next got dok=%b aok=%b data=%h want 0 1 0",
                        bus0.resp_data_ok, bus0.resp_addr_ok, bus0.resp_data);
    end
    set_req(1'b1, 1'b0, '0, 3'd0, 8'h00, '0);
  endtask

  task automatic test_errors;
    logic ao, er; int lat; logic [63:0] rd;
    xfer(1'b0, 64'h8000_1FF8, 3'd3, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, ao, lat, rd, er);
    xfer(1'b0, 64'h8000_0000, 3'd3, 8'hFF, 64'hC3C3_C3C3_C3C3_C3C3, ao, lat, rd, er);
    xfer(1'b0, 64'h8000_0003, 3'd2, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (lat != 3 || er !== 1'b1 || rd !== 64'h0) begin
      n_bad++; $display("FAIL misaligned got lat=%0d err=%b data=%h want 3 1 0", lat, er, rd);
    end
    xfer(1'b0, 64'h8000_0004, 3'd2, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (er !== 1'b0 || rd !== 64'hC3C3_C3C3_C3C3_C3C3) begin
      n_bad++; $display("FAIL aligned_word got err=%b data=%h want 0 c3c3c3c3c3c3c3c3", er, rd);
    end
    xfer(1'b0, 64'h8000_2000, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, ao, lat, rd, er);
    n_cmp++;
    if (lat != 3 || er !== 1'b1 || rd !== 64'h0) begin
      n_bad++; $display("FAIL out_of_range got lat=%0d err=%b data=%h want 3 1 0", lat, er, rd);
    end
    xfer(1'b0, 64'h7FFF_FFF8, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      n_bad++; $display("FAIL below_base got err=%b data=%h want 1 0", er, rd);
    end
    xfer(1'b0, 64'h8000_0008, 3'd4, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      n_bad++; $display("FAIL bad_size got err=%b data=%h want 1 0", er, rd);
    end
    xfer(1'b0, 64'h8000_1FF8, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (er !== 1'b0 || rd !== 64'h5A5A_5A5A_5A5A_5A5A) begin
      n_bad++; $display("FAIL last_word got err=%b data=%h want 0 5a5a5a5a5a5a5a5a", er, rd);
    end
    xfer(1'b0, 64'h8000_0000, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (rd !== 64'hC3C3_C3C3_C3C3_C3C3) begin
      n_bad++; $display("FAIL first_word got %h want c3c3c3c3c3c3c3c3", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic ao, er; int lat; logic [63:0] rd; int seen;
    @(negedge clk);
    set_req(1'b0, 1'b1, 64'h8000_0008, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); #1;
    reset = 1'b0;
    set_req(1'b0, 1'b0, '0, 3'd0, 8'h00, '0);
    #1;
    n_cmp++;
    if (bus2.resp_data_ok !== 1'b0 || bus2.resp_err !== 1'b0 || bus2.resp_data !== 64'h0) begin
      n_bad++; $display("FAIL mid_reset_outputs got dok=%b err=%b data=%h want 0 0 0",
                        bus2.resp_data_ok, bus2.resp_err, bus2.resp_data);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus2.resp_data_ok) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL mid_reset_no_dok got %0d pulses want 0", seen);
    end
    xfer(1'b0, 64'h8000_0008, 3'd3, 8'h00, '0, ao, lat, rd, er);
    n_cmp++;
    if (ao !== 1'b1 || lat != 3 || rd !== 64'h1122_3344_5566_7788) begin
      n_bad++; $display("FAIL mid_reset_old_value got aok=%b lat=%0d data=%h want 1 3 1122334455667788",
                        ao, lat, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic ao, er; int lat; logic [63:0] rd;
    logic [63:0] ev [4];
    logic [63:0] ea [4];
    int k;
    ea[0] = 64'h8000_0100; ev[0] = 64'hA0A0_0000_0000_0001;
    ea[1] = 64'h8000_0108; ev[1] = 64'hB1B1_0000_0000_0002;
    ea[2] = 64'h8000_0110; ev[2] = 64'hC2C2_0000_0000_0003;
    ea[3] = 64'h8000_0118; ev[3] = 64'hD3D3_0000_0000_0004;
    for (int i = 0; i < 4; i++) xfer(1'b0, ea[i], 3'd3, 8'hFF, ev[i], ao, lat, rd, er);
    k = 0;
    @(negedge clk);
    set_req(1'b0, 1'b1, ea[0], 3'd3, 8'h00, '0);
    for (int c = 0; c <= 17; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus2.resp_data_ok) begin
        n_cmp++;
        if (k > 3 || c != 3 + 4*k || bus2.resp_data !== ev[k & 3] || bus2.resp_err !== 1'b0) begin
          n_bad++; $display("FAIL b2b_%0d got cycle=%0d data=%h want cycle=%0d data=%h",
                            k, c, bus2.resp_data, 3 + 4*k, ev[k & 3]);
        end
        k++;
        if (k < 4) set_req(1'b0, 1'b1, ea[k], 3'd3, 8'h00, '0);
        else       set_req(1'b0, 1'b0, '0, 3'd0, 8'h00, '0);
      end
    end
    set_req(1'b0, 1'b0, '0, 3'd0, 8'h00, '0);
    n_cmp++;
    if (k != 4) begin
      n_bad++; $display("FAIL b2b_count got %0d responses want 4", k);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_merge;
    test_latency0;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
